// File: rtl/lsu_dmem_ctrl_if.sv
// Bundle between the MEM-stage requester, the load/store controller and the word-wide data memory.
// The requester/memory side uses the master modport; the controller uses the slave modport.
interface lsu_dmem_ctrl_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  // Handshake: a request transfers at a posedge where req_valid_i && req_ready_o.
  // The requester holds its fields stable while valid is high and the request is not yet taken.
  // Each accepted request gets exactly one single-cycle resp_valid_o pulse.
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [1:0]    req_size_i;
  logic          req_unsigned_i;
  logic [31:0]   req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic          resp_valid_o;
  logic [DW-1:0] resp_rdata_o;
  logic          resp_err_o;
  logic [AW-1:0] Addr_o;
  logic          Read_en_o;
  logic          Write_en_o;
  logic [DW-1:0] Wr_data_o;
  logic [DW-1:0] Read_data_i;

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output Read_data_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    input  Addr_o, Read_en_o, Write_en_o, Wr_data_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  Read_data_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    output Addr_o, Read_en_o, Write_en_o, Wr_data_o
  );
endinterface

// File: rtl/lsu_dmem_ctrl.sv
// RV32 load/store controller for a word-only memory: sub-word stores are read-modify-write,
// loads are lane-extracted and extended. One request in flight at a time.
module lsu_dmem_ctrl #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  lsu_dmem_ctrl_if.slave      bus,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  state_t        state;
  logic          ld_we;
  logic          ld_uns;
  logic [1:0]    ld_size;
  logic [1:0]    ld_off;
  logic [15:0]   ld_wdata;

  logic          req_err;
  logic [DW-1:0] shifted;
  logic [DW-1:0] load_val;
  logic [DW-1:0] merged;

  assign dbg_state_o = state;

  always_comb begin
    req_err = 1'b0;
    if (bus.req_size_i == 2'b11) req_err = 1'b1;
    if (bus.req_size_i == SZ_H && bus.req_addr_i[0]) req_err = 1'b1;
    if (bus.req_size_i == SZ_W && bus.req_addr_i[1:0] != 2'b00) req_err = 1'b1;
    if (bus.req_addr_i[31:AW+2] != '0) req_err = 1'b1;
  end

  // Load extraction and store merge both work on the word read during RD.
  always_comb begin
    shifted = bus.Read_data_i >> {ld_off, 3'b000};
    case (ld_size)
      SZ_B:    load_val = {{(DW-8){~ld_uns & shifted[7]}}, shifted[7:0]};
      SZ_H:    load_val = {{(DW-16){~ld_uns & shifted[15]}}, shifted[15:0]};
      default: load_val = bus.Read_data_i;
    endcase
    merged = bus.Read_data_i;
    if (ld_size == SZ_B) merged[{ld_off, 3'b000} +: 8] = ld_wdata[7:0];
    else                 merged[{ld_off[1], 4'b0000} +: 16] = ld_wdata[15:0];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state            <= IDLE;
      bus.req_ready_o  <= 1'b1;
      bus.resp_valid_o <= 1'b0;
      bus.resp_err_o   <= 1'b0;
      bus.resp_rdata_o <= '0;
      bus.Addr_o       <= '0;
      bus.Read_en_o    <= 1'b0;
      bus.Write_en_o   <= 1'b0;
      bus.Wr_data_o    <= '0;
      ld_we            <= 1'b0;
      ld_uns           <= 1'b0;
      ld_size          <= SZ_B;
      ld_off           <= 2'b00;
      ld_wdata         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid_i && bus.req_ready_o) begin
            ld_we           <= bus.req_we_i;
            ld_uns          <= bus.req_unsigned_i;
            ld_size         <= bus.req_size_i;
            ld_off          <= bus.req_addr_i[1:0];
            ld_wdata        <= bus.req_wdata_i[15:0];
            bus.req_ready_o <= 1'b0;
            if (req_err) begin
              // Rejected requests never reach the memory port.
              state            <= RESP;
              bus.resp_valid_o <= 1'b1;
              bus.resp_err_o   <= 1'b1;
              bus.resp_rdata_o <= '0;
            end else if (bus.req_we_i && bus.req_size_i == SZ_W) begin
              state          <= WR;
              bus.Addr_o     <= bus.req_addr_i[AW+1:2];
              bus.Write_en_o <= 1'b1;
              bus.Wr_data_o  <= bus.req_wdata_i;
            end else begin
              state         <= RD;
              bus.Addr_o    <= bus.req_addr_i[AW+1:2];
              bus.Read_en_o <= 1'b1;
            end
          end
        end
        RD: begin
          bus.Read_en_o <= 1'b0;
          if (ld_we) begin
            state          <= WR;
            bus.Write_en_o <= 1'b1;
            bus.Wr_data_o  <= merged;
          end else begin
            state            <= RESP;
            bus.resp_valid_o <= 1'b1;
            bus.resp_err_o   <= 1'b0;
            bus.resp_rdata_o <= load_val;
          end
        end
        WR: begin
          state            <= RESP;
          bus.Write_en_o   <= 1'b0;
          bus.resp_valid_o <= 1'b1;
          bus.resp_err_o   <= 1'b0;
          bus.resp_rdata_o <= '0;
        end
        default: begin
          state            <= IDLE;
          bus.req_ready_o  <= 1'b1;
          bus.resp_valid_o <= 1'b0;
          bus.resp_err_o   <= 1'b0;
          bus.resp_rdata_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Directed plus lightly randomised bench for lsu_dmem_ctrl with a negedge-sampled memory model
// and an expected-response queue.
module tb_lsu_dmem_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef logic [DW:0] exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  lsu_dmem_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  lsu_dmem_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  // Word memory: samples address/enables on negedge, read data valid from that negedge.
  logic [DW-1:0] mem [32];
  bit            mem_inited = 1'b0;
  int            rd_cnt = 0;
  int            wr_cnt = 0;
  logic [AW-1:0] last_rd_addr = '0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [DW-1:0] last_wr_data = '0;
  bit            both_en = 1'b0;

  always @(negedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      mem[0]     <= 32'h8000_0002;
      mem[1]     <= 32'h0000_000C;
      mem[2]     <= 32'h5566_7788;
      mem_inited <= 1'b1;
    end else if (bus.Write_en_o) begin
      mem[bus.Addr_o] <= bus.Wr_data_o;
    end
    if (bus.Write_en_o) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= bus.Addr_o;
      last_wr_data <= bus.Wr_data_o;
    end
    if (bus.Read_en_o) begin
      rd_cnt       <= rd_cnt + 1;
      last_rd_addr <= bus.Addr_o;
    end
    if (bus.Read_en_o && bus.Write_en_o) both_en <= 1'b1;
    bus.Read_data_i <= bus.Read_en_o ? mem[bus.Addr_o] : '0;
  end

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_resp(input string tag, input int exp_lat);
    int   lat = 0;
    bit   got = 1'b0;
    exp_t e;
    while (!got && lat < 12) begin
      @(negedge clk);
      lat++;
      if (bus.resp_valid_o) got = 1'b1;
    end
    chk({tag, "_resp_seen"}, got, 1);
    if (got) begin
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_q_nonempty"}, exp_q.size() > 0, 1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk({tag, "_err"}, bus.resp_err_o, e[DW]);
      chk({tag, "_rdata"}, bus.resp_rdata_o, e[DW-1:0]);
      @(negedge clk);
      chk({tag, "_pulse_end"}, {bus.resp_valid_o, bus.resp_err_o, bus.resp_rdata_o}, '0);
    end
  endtask

  task automatic send(input bit we, input logic [1:0] size, input bit uns,
                      input logic [31:0] addr, input logic [DW-1:0] wdata);
    int n = 0;
    @(negedge clk);
    bus.req_we_i       = we;
    bus.req_size_i     = size;
    bus.req_unsigned_i = uns;
    bus.req_addr_i     = addr;
    bus.req_wdata_i    = wdata;
    bus.req_valid_i    = 1'b1;
    while (!bus.req_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", bus.req_ready_o, 1);
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic txn(input string tag, input bit we, input logic [1:0] size, input bit uns,
                     input logic [31:0] addr, input logic [DW-1:0] wdata,
                     input bit exp_err, input logic [DW-1:0] exp_rdata, input int exp_lat);
    exp_q.push_back({exp_err, exp_rdata});
    send(we, size, uns, addr, wdata);
    wait_resp(tag, exp_lat);
  endtask

  initial begin
    int            rd0;
    int            wr0;
    int            k;
    logic [7:0]    d;
    logic [DW-1:0] w;
    exp_t          e;
    bit            any_resp;

    bus.req_valid_i    = 1'b0;
    bus.req_we_i       = 1'b0;
    bus.req_size_i     = 2'b00;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i     = '0;
    bus.req_wdata_i    = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.req_ready_o, 1);
    chk("rst_outputs", {bus.resp_valid_o, bus.resp_err_o, bus.Read_en_o, bus.Write_en_o}, 0);
    chk("rst_addr", bus.Addr_o, 0);
    chk("rst_wr_data", bus.Wr_data_o, 0);
    chk("rst_rdata", bus.resp_rdata_o, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1;

    // LW from word 0
    #1; rd0 = rd_cnt;
    txn("lw0", 1'b0, 2'b10, 1'b0, 32'h00, '0, 1'b0, 32'h8000_0002, 2);
    #1;
    chk("lw0_reads", rd_cnt - rd0, 1);
    chk("lw0_rd_addr", last_rd_addr, 0);

    // Sub-word loads and extension
    txn("lb3",  1'b0, 2'b00, 1'b0, 32'h03, '0, 1'b0, 32'hFFFF_FF80, 2);
    txn("lbu3", 1'b0, 2'b00, 1'b1, 32'h03, '0, 1'b0, 32'h0000_0080, 2);
    txn("lh2",  1'b0, 2'b01, 1'b0, 32'h02, '0, 1'b0, 32'hFFFF_8000, 2);
    txn("lh8",  1'b0, 2'b01, 1'b0, 32'h08, '0, 1'b0, 32'h0000_7788, 2);
    txn("lb9",  1'b0, 2'b00, 1'b0, 32'h09, '0, 1'b0, 32'h0000_0077, 2);

    // SB read-modify-write into word 1
    #1; rd0 = rd_cnt; wr0 = wr_cnt;
    txn("sb5", 1'b1, 2'b00, 1'b0, 32'h05, 32'h0000_00AB, 1'b0, '0, 3);
    #1;
    chk("sb5_reads", rd_cnt - rd0, 1);
    chk("sb5_writes", wr_cnt - wr0, 1);
    chk("sb5_addr", {last_rd_addr, last_wr_addr}, {5'd1, 5'd1});
    chk("sb5_wr_data", last_wr_data, 32'h0000_AB0C);
    txn("lw4", 1'b0, 2'b10, 1'b0, 32'h04, '0, 1'b0, 32'h0000_AB0C, 2);

    // SH into the upper half of word 2
    txn("sha", 1'b1, 2'b01, 1'b0, 32'h0A, 32'hFFFF_1234, 1'b0, '0, 3);
    txn("lw8", 1'b0, 2'b10, 1'b0, 32'h08, '0, 1'b0, 32'h1234_7788, 2);
    txn("lhua", 1'b0, 2'b01, 1'b1, 32'h0A, '0, 1'b0, 32'h0000_1234, 2);

    // Errors never reach memory
    #1; rd0 = rd_cnt; wr0 = wr_cnt;
    txn("err_lh1",  1'b0, 2'b01, 1'b0, 32'h01, '0, 1'b1, '0, 1);
    txn("err_lw2",  1'b0, 2'b10, 1'b0, 32'h02, '0, 1'b1, '0, 1);
    txn("err_sz3",  1'b0, 2'b11, 1'b0, 32'h00, '0, 1'b1, '0, 1);
    txn("err_lw80", 1'b0, 2'b10, 1'b0, 32'h80, '0, 1'b1, '0, 1);
    txn("err_sw_oor", 1'b1, 2'b10, 1'b0, 32'h8000_0000, 32'h1, 1'b1, '0, 1);
    #1;
    chk("err_no_enables", {rd_cnt - rd0, wr_cnt - wr0}, 0);

    // Random byte stores into word 4, checked against a local word model
    w = '0;
    for (int i = 0; i < 6; i++) begin
      k = $urandom_range(0, 3);
      d = 8'($urandom_range(0, 255));
      w[k*8 +: 8] = d;
      txn("rnd_sb", 1'b1, 2'b00, 1'b0, 32'h10 + 32'(k), {24'hABCDEF, d}, 1'b0, '0, 3);
    end
    txn("rnd_lw", 1'b0, 2'b10, 1'b0, 32'h10, '0, 1'b0, w, 2);
    k = $urandom_range(0, 3);
    txn("rnd_lb", 1'b0, 2'b00, 1'b0, 32'h10 + 32'(k), '0, 1'b0,
        {{24{w[k*8+7]}}, w[k*8 +: 8]}, 2);

    // Back-to-back with valid held high
    exp_q.push_back({1'b0, 32'h0});
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    @(negedge clk);
    bus.req_we_i = 1'b1; bus.req_size_i = 2'b10; bus.req_unsigned_i = 1'b0;
    bus.req_addr_i = 32'h08; bus.req_wdata_i = 32'hDEAD_BEEF; bus.req_valid_i = 1'b1;
    chk("b2b_ready_idle", bus.req_ready_o, 1);
    @(posedge clk); #1;
    bus.req_we_i = 1'b0; bus.req_wdata_i = '0;
    @(negedge clk);
    chk("b2b_busy_wr", {bus.req_ready_o, bus.Write_en_o, bus.Read_en_o}, 3'b010);
    @(negedge clk);
    chk("b2b_busy_resp", {bus.req_ready_o, bus.resp_valid_o}, 2'b01);
    e = exp_q.pop_front();
    chk("b2b_sw_resp", {bus.resp_err_o, bus.resp_rdata_o}, e);
    chk("b2b_sw_mem", {last_wr_addr, last_wr_data}, {5'd2, 32'hDEAD_BEEF});
    @(negedge clk);
    chk("b2b_ready_again", bus.req_ready_o, 1);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    wait_resp("b2b_lw", 2);

    // Reset during the write cycle of a SW
    @(negedge clk);
    bus.req_we_i = 1'b1; bus.req_size_i = 2'b10; bus.req_addr_i = 32'h0C;
    bus.req_wdata_i = 32'hCAFE_F00D; bus.req_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    chk("abort_in_wr", bus.Write_en_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we_drop", bus.Write_en_o, 0);
    chk("abort_ready", bus.req_ready_o, 1);
    chk("abort_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    any_resp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.resp_valid_o) any_resp = 1'b1;
    end
    chk("abort_no_resp", any_resp, 0);
    chk("abort_idle", {dbg_state, bus.req_ready_o}, 3'b001);
    txn("post_rst_lw", 1'b0, 2'b10, 1'b0, 32'h00, '0, 1'b0, 32'h8000_0002, 2);

    chk("never_both_enables", both_en, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
